// File: rtl/sram_to_l0_loader.sv
// sram_to_l0_loader: streams weights then im2col activations per kernel position from SRAM into L0.
// Optional stall counter enabled by defining SRAM_TO_L0_STALL_CNT_EN.
module sram_to_l0_loader #(
  parameter int bw         = 4,
  parameter int row        = 8,
  parameter int addr_width = 8,
  parameter int len_onij   = 16,
  parameter int len_kij    = 9,
  parameter int W_BASE     = 0,
  parameter int X_BASE     = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  l0_full_i,
  input  logic [row*bw-1:0]     sram_q_i,
  output logic                  sram_cen_o,
  output logic                  sram_wen_o,
  output logic [addr_width-1:0] sram_addr_o,
  output logic                  l0_wr_o,
  output logic [row*bw-1:0]     l0_in_o,
  output logic [3:0]            kij_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           stall_cnt_o
);
  typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_X, DRAIN} state_t;
  state_t state_q;
  logic [2:0] r_q;
  logic [4:0] n_q;
  logic [3:0] kij_q;
  logic [1:0] kx_q, ky_q, col_q, prow_q;
  logic cen_q, wr_q, busy_q, done_q;
  logic [addr_width-1:0] addr_q, w_addr_d, x_addr_d;
  // kx/ky track kij%3, kij/3 and col/prow track n%4, n/4 so no divider is needed
  always_comb begin
    w_addr_d = addr_width'(W_BASE + int'(kij_q) * row + int'(r_q));
    x_addr_d = addr_width'(X_BASE + (int'(prow_q) + int'(ky_q)) * 6 + int'(col_q) + int'(kx_q));
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      n_q     <= '0;
      kij_q   <= '0;
      kx_q    <= '0;
      ky_q    <= '0;
      col_q   <= '0;
      prow_q  <= '0;
      cen_q   <= 1'b1;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      cen_q  <= 1'b1;
      wr_q   <= ~cen_q;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= LOAD_W;
          busy_q  <= 1'b1;
          r_q     <= '0;
          n_q     <= '0;
          kij_q   <= '0;
          kx_q    <= '0;
          ky_q    <= '0;
          col_q   <= '0;
          prow_q  <= '0;
        end
        LOAD_W: if (!l0_full_i) begin
          cen_q  <= 1'b0;
          addr_q <= w_addr_d;
          r_q    <= r_q + 3'd1;
          if (r_q == 3'(row - 1)) begin
            state_q <= LOAD_X;
            r_q     <= '0;
          end
        end
        LOAD_X: if (!l0_full_i) begin
          cen_q  <= 1'b0;
          addr_q <= x_addr_d;
          n_q    <= n_q + 5'd1;
          col_q  <= col_q + 2'd1;
          prow_q <= col_q == 2'd3 ? prow_q + 2'd1 : prow_q;
          if (n_q == 5'(len_onij - 1)) begin
            state_q <= DRAIN;
            n_q     <= '0;
            col_q   <= '0;
            prow_q  <= '0;
          end
        end
        DRAIN: if (kij_q == 4'(len_kij - 1)) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= LOAD_W;
          kij_q   <= kij_q + 4'd1;
          kx_q    <= kx_q == 2'd2 ? 2'd0 : kx_q + 2'd1;
          ky_q    <= kx_q == 2'd2 ? ky_q + 2'd1 : ky_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef SRAM_TO_L0_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk) begin
    if (!reset) stall_q <= '0;
    else if (state_q == IDLE && start_i) stall_q <= '0;
    else if ((state_q == LOAD_W || state_q == LOAD_X) && l0_full_i && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif
  assign sram_cen_o  = cen_q;
  assign sram_wen_o  = 1'b1;
  assign sram_addr_o = addr_q;
  assign l0_wr_o     = wr_q;
  assign l0_in_o     = wr_q ? sram_q_i : '0;
  assign kij_o       = kij_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
endmodule

// File: tb/tb_sram_to_l0_loader.sv
// tb_sram_to_l0_loader: random-data SRAM model and an address/data scoreboard for the loader.
module tb_sram_to_l0_loader;
  logic clk = 0, reset = 0, start_i = 0, l0_full_i = 0;
  logic [31:0] sram_q_i = '0;
  logic sram_cen_o, sram_wen_o, l0_wr_o, busy_o, done_o;
  logic [7:0] sram_addr_o;
  logic [31:0] l0_in_o;
  logic [3:0] kij_o;
  logic [15:0] stall_cnt_o;
  sram_to_l0_loader dut (
    .clk(clk), .reset(reset), .start_i(start_i), .l0_full_i(l0_full_i), .sram_q_i(sram_q_i),
    .sram_cen_o(sram_cen_o), .sram_wen_o(sram_wen_o), .sram_addr_o(sram_addr_o), .l0_wr_o(l0_wr_o),
    .l0_in_o(l0_in_o), .kij_o(kij_o), .busy_o(busy_o), .done_o(done_o), .stall_cnt_o(stall_cnt_o)
  );
  always #5 clk = ~clk;
  logic [31:0] mem [256];
  int checks = 0, errors = 0;
  int iss = 0, wr = 0, done_cnt = 0, cyc = 0, first_c = 0, last_c = 0;
  int got_addr [216];
  int exp_stall;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic int ea(input int i);
    int k = i / 24, j = i % 24;
    return j < 8 ? k * 8 + j : 128 + ((j - 8) / 4 + k / 3) * 6 + (j - 8) % 4 + k % 3;
  endfunction
  always @(posedge clk) if (!sram_cen_o) sram_q_i <= mem[sram_addr_o];
  always @(posedge clk) begin
    #1;
    cyc++;
    if (reset) begin
      if (!sram_cen_o) begin
        if (iss < 216) begin
          got_addr[iss] = int'(sram_addr_o);
          chk("rd_addr", 32'(sram_addr_o), 32'(ea(iss)));
        end else chk("extra_rd", 32'(iss), 32'd215);
        iss++;
      end
      if (l0_wr_o) begin
        if (wr < 216) chk("wr_data", l0_in_o, mem[ea(wr)]);
        else chk("extra_wr", 32'(wr), 32'd215);
        if (wr == 0) first_c = cyc;
        last_c = cyc;
        wr++;
      end
      if (done_o) done_cnt++;
    end
  end
  task automatic clr();
    iss = 0; wr = 0; done_cnt = 0; first_c = 0; last_c = 0;
  endtask
  task automatic pulse_start();
    @(negedge clk); start_i = 1;
    @(negedge clk); start_i = 0;
  endtask
  task automatic run(input bit rnd);
    int c = 0;
    while (done_cnt == 0 && c < 5000) begin
      @(negedge clk);
      l0_full_i = rnd ? ($urandom_range(3) == 0) : 1'b0;
      c++;
    end
    l0_full_i = 0;
    repeat (3) @(negedge clk);
    chk("timeout", 32'(c < 5000), 32'd1);
  endtask
  task automatic chk_reset_vals();
    chk("rst_cen", 32'(sram_cen_o), 32'd1);
    chk("rst_wen", 32'(sram_wen_o), 32'd1);
    chk("rst_addr", 32'(sram_addr_o), 32'd0);
    chk("rst_wr", 32'(l0_wr_o), 32'd0);
    chk("rst_in", l0_in_o, 32'd0);
    chk("rst_kij", 32'(kij_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_stall", 32'(stall_cnt_o), 32'd0);
  endtask
  initial begin
    int c;
    foreach (mem[i]) mem[i] = $urandom;
`ifdef SRAM_TO_L0_STALL_CNT_EN
    exp_stall = 5;
`else
    exp_stall = 0;
`endif
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset = 1;
    repeat (2) @(negedge clk);
    // plain run, no back-pressure
    clr();
    pulse_start();
    chk("busy_run", 32'(busy_o), 32'd1);
    run(0);
    chk("n_wr", 32'(wr), 32'd216);
    chk("n_rd", 32'(iss), 32'd216);
    chk("n_done", 32'(done_cnt), 32'd1);
    chk("wr_span", 32'(last_c - first_c + 1), 32'd224);
    chk("addr_first", 32'(got_addr[0]), 32'd0);
    chk("addr_x0", 32'(got_addr[8]), 32'd128);
    chk("addr_k8n15", 32'(got_addr[215]), 32'd163);
    chk("addr_k4r0", 32'(got_addr[96]), 32'd32);
    chk("addr_k4n0", 32'(got_addr[104]), 32'd135);
    chk("stall_none", 32'(stall_cnt_o), 32'd0);
    chk("busy_end", 32'(busy_o), 32'd0);
    // five-cycle stall in LOAD_X, raised while a write is pending
    clr();
    pulse_start();
    c = 0;
    while (!(iss >= 13 && !sram_cen_o) && c < 200) begin @(negedge clk); c++; end
    chk("stall_reach", 32'(c < 200), 32'd1);
    l0_full_i = 1;
    @(posedge clk); #2;
    chk("pend_wr", 32'(l0_wr_o), 32'd1);
    chk("withheld", 32'(sram_cen_o), 32'd1);
    c = iss;
    repeat (4) @(negedge clk);
    @(negedge clk);
    chk("no_rd_stall", 32'(iss), 32'(c));
    l0_full_i = 0;
    run(0);
    chk("n_wr_stall", 32'(wr), 32'd216);
    chk("stall_cnt", 32'(stall_cnt_o), 32'(exp_stall));
    // random back-pressure with a second start during LOAD_W
    clr();
    pulse_start();
    repeat (2) @(negedge clk);
    start_i = 1;
    @(negedge clk); start_i = 0;
    run(1);
    chk("n_wr_rnd", 32'(wr), 32'd216);
    chk("n_done_rnd", 32'(done_cnt), 32'd1);
    // reset in the middle of kij=3 activations
    clr();
    pulse_start();
    c = 0;
    while (iss < 82 && c < 400) begin @(negedge clk); c++; end
    chk("kij3_reach", 32'(kij_o), 32'd3);
    reset = 0;
    @(posedge clk); #2;
    chk_reset_vals();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      chk("rst_no_wr", 32'(l0_wr_o), 32'd0);
    end
    @(negedge clk); reset = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("idle_no_wr", 32'(l0_wr_o), 32'd0);
    end
    clr();
    pulse_start();
    run(0);
    chk("restart_addr", 32'(got_addr[0]), 32'd0);
    chk("n_wr_restart", 32'(wr), 32'd216);
    chk("n_done_restart", 32'(done_cnt), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_to_l0_loader.md
SRAM_TO_L0_LOADER -- requirements
Module: sram_to_l0_loader

Interface
Parameters (name, default, meaning):
REQ-001 bw, 4: bits per element.
REQ-002 row, 8: elements per L0 word, equal to the array input channels.
REQ-003 addr_width, 8: SRAM address width.
REQ-004 len_onij, 16: output pixels per kij, forming a 4x4 output map.
REQ-005 len_kij, 9: kernel positions, forming a 3x3 kernel.
REQ-006 W_BASE, 0: SRAM base address of the weight block.
REQ-007 X_BASE, 128: SRAM base address of the 6x6 activation map.

Ports (name, direction, width, meaning):
REQ-008 clk, in, 1: single clock; all logic on its rising edge.
REQ-009 reset, in, 1: synchronous, active-low reset; the block is in reset while reset==0 at a rising edge.
REQ-010 start_i, in, 1: begin one full layer load; sampled only in IDLE.
REQ-011 l0_full_i, in, 1: L0 almost-full flag; high when fewer than 2 free entries remain.
REQ-012 sram_q_i, in, row*bw: SRAM read data, valid 1 cycle after the read issue.
REQ-013 sram_cen_o, out, 1: SRAM chip enable, active-low.
REQ-014 sram_wen_o, out, 1: SRAM write enable, active-low; held at 1 (read-only use).
REQ-015 sram_addr_o, out, addr_width: SRAM read address.
REQ-016 l0_wr_o, out, 1: L0 write strobe.
REQ-017 l0_in_o, out, row*bw: L0 write data.
REQ-018 kij_o, out, 4: current kernel index.
REQ-019 busy_o, out, 1: high in every state except IDLE.
REQ-020 done_o, out, 1: one-cycle pulse when the layer load completes.
REQ-021 stall_cnt_o, out, 16: count of stalled cycles (see Configuration).

Function
REQ-022 States: IDLE, LOAD_W, LOAD_X, DRAIN. All outputs are registered.
REQ-023 IDLE -> LOAD_W when start_i==1; kij and all counters clear to 0.
REQ-024 LOAD_W issues one read per cycle while l0_full_i==0: sram_cen_o=0, addr = W_BASE + kij*row + r, with r running 0..row-1.
REQ-025 LOAD_W -> LOAD_X after the read with r=row-1 is issued.
REQ-026 LOAD_X issues one read per cycle while l0_full_i==0 for n = 0..len_onij-1.
REQ-027 LOAD_X address = X_BASE + (n/4 + kij/3)*6 + (n%4 + kij%3); division and modulo are implemented with counters, not dividers.
REQ-028 LOAD_X -> DRAIN after the read with n=len_onij-1 is issued.
REQ-029 DRAIN lasts exactly 1 cycle. It then goes to LOAD_W with kij+1 if kij<len_kij-1; otherwise it goes to IDLE and pulses done_o in that same cycle.
REQ-030 While l0_full_i==1, no read is issued (sram_cen_o=1). Address and counters hold, and the state does not advance.
REQ-031 Latency: l0_wr_o=1 exactly 1 cycle after each issued read, with l0_in_o = sram_q_i from that cycle. No read is ever dropped or duplicated.
REQ-032 An in-flight write completes even if l0_full_i rises in its cycle; the 2-entry slack covers it.
REQ-033 Exactly len_kij*(row+len_onij) = 216 L0 writes per start. Order per kij: 8 weights, then 16 activations.
REQ-034 start_i is ignored while busy_o==1.
REQ-035 Counter widths: r is 3 bits, n is 5 bits, kij is 4 bits. None of them wraps within a layer.

Reset
REQ-036 When reset==0 at a clock edge, the block enters IDLE with: sram_cen_o=1, sram_wen_o=1, sram_addr_o=0, l0_wr_o=0, l0_in_o=0, kij_o=0, busy_o=0, done_o=0, stall_cnt_o=0.
REQ-037 Reset mid-operation discards any pending in-flight write, so no l0_wr_o occurs after reset.

Configuration
REQ-038 Macro SRAM_TO_L0_STALL_CNT_EN.
- Defined: stall_cnt_o increments in each cycle where the state is LOAD_W or LOAD_X and l0_full_i==1. It saturates at 16'hFFFF and clears on start.
- Undefined: stall_cnt_o is tied to 0 and no counter logic exists. All other behaviour is identical.

Verification
REQ-039 start_i pulse, l0_full_i=0 throughout -> 216 consecutive l0_wr_o except for 1 gap cycle per kij (the DRAIN cycle). The first address is 0, the kij0 activation addresses start at 128, and done_o pulses once.
REQ-040 Address check, kij=8, n=15 -> sram_addr_o=163. kij=4 weight r=0 -> address 32. kij=4, n=0 -> address 135.
REQ-041 l0_full_i held high for 5 cycles in the middle of LOAD_X -> no reads for those 5 cycles, the sequence resumes at the next n with no missing or duplicate data, and stall_cnt_o=5 when the macro is defined (0 when undefined).
REQ-042 start_i asserted again during LOAD_W -> ignored; the total write count is still 216.
REQ-043 reset driven to 0 during LOAD_X of kij=3, then released and start_i asserted -> all outputs at reset values, no stray write, and the load restarts at kij=0, address 0.
REQ-044 l0_full_i rising in the same cycle as a pending write -> that write still occurs and the next read is withheld.
